// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch PC sequencer.
// Provides the FSM state enum, default PCs and the alignment mask helper.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

    // Mask that clears the byte-offset bits below one instruction.
    function automatic logic [63:0] align_mask(input int unsigned bytes);
        return ~(64'(bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_target_align.sv
// Redirect target alignment: masks the byte-offset bits and flags a
// misaligned target.  Ports: target_i in, aligned_o / misaligned_o out.
module pc_target_align
    import pc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] aligned_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(INSTR_BYTES));

    assign aligned_o    = target_i & MASK;
    assign misaligned_o = |(target_i & ~MASK);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: steps the PC on accepted fetches, takes redirects
// and trap entry (trap > redirect > step > hold), and runs a
// BOOT/RUN/HALTED FSM.  PC is offered to fetch via pc_valid/pc_ready.
// Inputs : clk, reset (async, high), pc_ready, redirect_valid,
//          redirect_target, trap, halt, resume.
// Outputs: pc_valid, pc, pc_next_seq, halted, fetch_count, misalign_err.
// Macro PC_MISALIGN_TRAP_EN: misaligned redirects trap instead of
// being silently aligned, and pulse misalign_err.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] TRAP_PC     = XLEN'(DEF_TRAP_PC),
    parameter int unsigned     INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            halt,
    input  logic            resume,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            halted,
    output logic [31:0]     fetch_count,
    output logic            misalign_err
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            merr_q, merr_d;

    logic [XLEN-1:0] aligned;
    logic            misaligned;
    logic            reject;
    logic [XLEN-1:0] redir_pc;
    logic            fire;

    pc_target_align #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_align (
        .target_i     (redirect_target),
        .aligned_o    (aligned),
        .misaligned_o (misaligned)
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign reject = misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign reject            = 1'b0;
`endif

    assign redir_pc    = reject ? TRAP_PC : aligned;
    assign pc_valid    = (state_q == RUN);
    assign fire        = pc_valid && pc_ready;
    assign pc          = pc_q;
    assign pc_next_seq = pc_q + XLEN'(INSTR_BYTES);
    assign halted      = (state_q == HALTED);
    assign fetch_count = cnt_q;
    assign misalign_err = merr_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        merr_d  = 1'b0;
        // A fetch accepted alongside a redirect/trap still counts.
        if (fire) begin
            cnt_d = cnt_q + 32'd1;
        end
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                if (trap) begin
                    pc_d = TRAP_PC;
                end
            end
            RUN: begin
                if (trap) begin
                    pc_d = TRAP_PC;
                end else if (redirect_valid) begin
                    pc_d   = redir_pc;
                    merr_d = reject;
                end else if (fire) begin
                    pc_d = pc_next_seq;
                end
                if (halt && !trap) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (trap) begin
                    pc_d    = TRAP_PC;
                    state_d = RUN;
                end else begin
                    // Redirects still land while halted; no fetch issued.
                    if (redirect_valid) begin
                        pc_d   = redir_pc;
                        merr_d = reject;
                    end
                    if (resume && !halt) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            merr_q  <= merr_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected
// post-edge state; a monitor pops and compares after each clock/reset edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        trap = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        pc_valid;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        halted;
    logic [31:0] fetch_count;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic [31:0] cnt;
        logic        m;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pc_ready        (pc_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .halt            (halt),
        .resume          (resume),
        .pc_valid        (pc_valid),
        .pc              (pc),
        .pc_next_seq     (pc_next_seq),
        .halted          (halted),
        .fetch_count     (fetch_count),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per clock or reset edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (pc !== e.pc || pc_valid !== e.v || halted !== e.h ||
                    fetch_count !== e.cnt || misalign_err !== e.m ||
                    pc_next_seq !== e.pc + 32'd4) begin
                    miscompares++;
                    $display("FAIL vec%0d: got pc=%h v=%b h=%b cnt=%0d m=%b nxt=%h want pc=%h v=%b h=%b cnt=%0d m=%b nxt=%h",
                             vectors, pc, pc_valid, halted, fetch_count,
                             misalign_err, pc_next_seq, e.pc, e.v, e.h,
                             e.cnt, e.m, e.pc + 32'd4);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic rdy, input logic rv,
                       input logic [31:0] tgt, input logic trp,
                       input logic hlt, input logic res,
                       input logic [31:0] epc, input logic ev,
                       input logic eh, input logic [31:0] ecnt,
                       input logic em);
        exp_t e;
        @(negedge clk);
        reset = rst;
        pc_ready = rdy;
        redirect_valid = rv;
        redirect_target = tgt;
        trap = trp;
        halt = hlt;
        resume = res;
        e = '{pc: epc, v: ev, h: eh, cnt: ecnt, m: em};
        q.push_back(e);
    endtask

    initial begin
        // Test 1: reset for 2 clks, then sequential fetch
        cyc(1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h4, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h8, 1, 0, 2, 0);
        // Test 2: stall at pc=8
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 2, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'hC, 1, 0, 3, 0);
        // Test 3: redirect with handshake at C
        cyc(0, 1, 1, 32'h2C, 0, 0, 0, 32'h2C, 1, 0, 4, 0);
        // Test 4: trap beats redirect; halt; redirect while halted; resume
        cyc(0, 1, 1, 32'h40, 1, 0, 0, 32'h100, 1, 0, 5, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 32'h104, 0, 1, 6, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 32'h104, 0, 1, 6, 0);
        cyc(0, 1, 1, 32'h80, 0, 0, 0, 32'h80, 0, 1, 6, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h80, 1, 0, 6, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h84, 1, 0, 7, 0);
        // Trap cancels halt
        cyc(0, 1, 0, 0, 0, 1, 0, 32'h88, 0, 1, 8, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 32'h100, 1, 0, 8, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h104, 1, 0, 9, 0);
        // Test 5: wrap at top of address space
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 9, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 10, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h4, 1, 0, 11, 0);
        // Async reset pulse between edges with a pending redirect
        cyc(0, 1, 1, 32'h40, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        q.push_back('{pc: 32'h0, v: 1'b1, h: 1'b0, cnt: 32'd0, m: 1'b0});
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h4, 1, 0, 1, 0);
        // Test 6: misaligned redirect
`ifdef PC_MISALIGN_TRAP_EN
        cyc(0, 1, 1, 32'h2E, 0, 0, 0, 32'h100, 1, 0, 2, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h104, 1, 0, 3, 0);
`else
        cyc(0, 1, 1, 32'h2E, 0, 0, 0, 32'h2C, 1, 0, 2, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h30, 1, 0, 3, 0);
`endif
        cyc(0, 0, 0, 0, 0, 0, 0, pc_expect_hold(), 1, 0, 3, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected records left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    function automatic logic [31:0] pc_expect_hold();
`ifdef PC_MISALIGN_TRAP_EN
        return 32'h104;
`else
        return 32'h30;
`endif
    endfunction

endmodule
